// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver types: FSM state encoding and parity mode constants
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Mode 2'b11 is deliberately treated as "no parity bit on the line".
  function automatic logic has_parity(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for a single asynchronous input
// Ports: clk, reset (async, active-high), d (async input), q (synchronised output).
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised oversampling UART receiver with parity and framing checks
// Ports: clk, reset (async, active-high), rx (serial line, idle high), s_tick (oversampling strobe),
//        parity_mode (00 none, 01 even, 10 odd, 11 none), rx_done_tick (one-clk frame pulse),
//        dout (received word), parity_err / frame_err (status of the last frame, held with dout).
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int OVS     = 16,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  input  logic [1:0]      parity_mode,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            parity_err,
  output logic            frame_err
);

  localparam int SW = $clog2(max_int(OVS, SB_TICK));
  localparam int NW = $clog2(DBIT + 1);

  localparam logic [SW-1:0] S_MID  = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OVS - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  logic rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  state_t          state, state_next;
  logic [SW-1:0]   s, s_next;
  logic [NW-1:0]   n, n_next;
  logic [DBIT-1:0] b, b_next;
  logic            par, par_next;
  logic            p_bit, p_bit_next;
  logic [1:0]      pm_r, pm_next;
  // Set after a frame whose stop bit was low (break); blocks start detection
  // until the line has been seen high again, so a held-low line is one frame.
  logic            hold_off, hold_off_next;
  logic [DBIT-1:0] dout_next;
  logic            perr_next, ferr_next, done_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      par          <= 1'b0;
      p_bit        <= 1'b0;
      pm_r         <= PAR_NONE;
      hold_off     <= 1'b0;
      dout         <= '0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      rx_done_tick <= 1'b0;
    end else begin
      state        <= state_next;
      s            <= s_next;
      n            <= n_next;
      b            <= b_next;
      par          <= par_next;
      p_bit        <= p_bit_next;
      pm_r         <= pm_next;
      hold_off     <= hold_off_next;
      dout         <= dout_next;
      parity_err   <= perr_next;
      frame_err    <= ferr_next;
      rx_done_tick <= done_next;
    end
  end

  always_comb begin
    state_next    = state;
    s_next        = s;
    n_next        = n;
    b_next        = b;
    par_next      = par;
    p_bit_next    = p_bit;
    pm_next       = pm_r;
    hold_off_next = hold_off;
    dout_next     = dout;
    perr_next     = parity_err;
    ferr_next     = frame_err;
    done_next     = 1'b0;

    case (state)
      // IDLE reacts every clk so a start edge right after a stop bit is caught.
      IDLE: begin
        if (hold_off) begin
          if (rx_s) hold_off_next = 1'b0;
        end else if (!rx_s) begin
          state_next = START;
          s_next     = '0;
          pm_next    = parity_mode;
        end
      end

      START: begin
        if (s_tick) begin
          if (s == S_MID) begin
            if (!rx_s) begin
              state_next = DATA;
              s_next     = '0;
              n_next     = '0;
              par_next   = 1'b0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_next = s + SW'(1);
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (s == S_BIT) begin
            b_next   = {rx_s, b[DBIT-1:1]};
            par_next = par ^ rx_s;
            s_next   = '0;
            n_next   = n + NW'(1);
            if (n == N_LAST) state_next = has_parity(pm_r) ? PARITY : STOP;
          end else begin
            s_next = s + SW'(1);
          end
        end
      end

      PARITY: begin
        if (s_tick) begin
          if (s == S_BIT) begin
            p_bit_next = rx_s;
            s_next     = '0;
            state_next = STOP;
          end else begin
            s_next = s + SW'(1);
          end
        end
      end

      STOP: begin
        if (s_tick) begin
          if (s == S_STOP) begin
            state_next    = IDLE;
            dout_next     = b;
            ferr_next     = ~rx_s;
            hold_off_next = ~rx_s;
            done_next     = 1'b1;
            case (pm_r)
              PAR_EVEN: perr_next = par ^ p_bit;
              PAR_ODD:  perr_next = ~(par ^ p_bit);
              default:  perr_next = 1'b0;
            endcase
          end else begin
            s_next = s + SW'(1);
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - self-checking bench for uart_rx_param (8-bit/1-stop and 7-bit/2-stop instances)
module tb_uart_rx_param;

  localparam int TDIV = 6;
  localparam int OVS  = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } res_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic [1:0] pm_a = 2'b00;
  logic [1:0] pm_b = 2'b00;

  logic       done_a, perr_a, ferr_a;
  logic [7:0] dout_a;
  logic       done_b, perr_b, ferr_b;
  logic [6:0] dout_b;

  int checks = 0;
  int passes = 0;

  res_t q_a[$];
  res_t q_b[$];
  res_t exp_a[$];
  res_t exp_b[$];

  uart_rx_param #(.DBIT(8), .OVS(16), .SB_TICK(16)) dut_a (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx_a),
    .s_tick       (s_tick),
    .parity_mode  (pm_a),
    .rx_done_tick (done_a),
    .dout         (dout_a),
    .parity_err   (perr_a),
    .frame_err    (ferr_a)
  );

  uart_rx_param #(.DBIT(7), .OVS(16), .SB_TICK(32)) dut_b (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx_b),
    .s_tick       (s_tick),
    .parity_mode  (pm_b),
    .rx_done_tick (done_b),
    .dout         (dout_b),
    .parity_err   (perr_b),
    .frame_err    (ferr_b)
  );

  always #10 clk = ~clk;

  initial begin
    forever begin
      repeat (TDIV - 1) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  // Every done pulse lands one record in the queue; a stretched pulse shows up as a duplicate.
  always @(negedge clk) begin
    if (done_a) q_a.push_back({dout_a, perr_a, ferr_a});
    if (done_b) q_b.push_back({1'b0, dout_b, perr_b, ferr_b});
  end

  // Reference: parity judged by total count of ones over data plus parity bit.
  function automatic res_t model(input logic [7:0] data, input logic [1:0] mode,
                                 input logic pbit, input logic stop_lvl);
    int   ones;
    res_t r;
    ones = $countones(data);
    if (mode == 2'b01 || mode == 2'b10) ones = ones + int'(pbit);
    r.d  = data;
    r.pe = (mode == 2'b01) ? (ones % 2 != 0) : (mode == 2'b10) ? (ones % 2 == 0) : 1'b0;
    r.fe = ~stop_lvl;
    return r;
  endfunction

  task automatic wait_ticks(input int cnt);
    int k = 0;
    while (k < cnt) begin
      @(posedge clk);
      if (s_tick) k++;
    end
    #1;
  endtask

  // parity_mode is scrambled after the start bit: the receiver must use the latched mode.
  task automatic send_a(input logic [7:0] data, input logic [1:0] mode, input logic pbit,
                        input logic stop_lvl);
    pm_a = mode;
    rx_a = 1'b0;
    wait_ticks(OVS);
    pm_a = 2'($urandom_range(0, 3));
    for (int i = 0; i < 8; i++) begin
      rx_a = data[i];
      wait_ticks(OVS);
    end
    if (mode == 2'b01 || mode == 2'b10) begin
      rx_a = pbit;
      wait_ticks(OVS);
    end
    rx_a = stop_lvl;
    wait_ticks(16);
    rx_a = 1'b1;
  endtask

  task automatic send_b(input logic [6:0] data, input logic [1:0] mode, input logic pbit);
    pm_b = mode;
    rx_b = 1'b0;
    wait_ticks(OVS);
    pm_b = 2'($urandom_range(0, 3));
    for (int i = 0; i < 7; i++) begin
      rx_b = data[i];
      wait_ticks(OVS);
    end
    if (mode == 2'b01 || mode == 2'b10) begin
      rx_b = pbit;
      wait_ticks(OVS);
    end
    rx_b = 1'b1;
    wait_ticks(32);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({done_a, dout_a, perr_a, ferr_a} !== 11'd0)
      $display("FAIL reset_a_outputs got %h exp 0", {done_a, dout_a, perr_a, ferr_a});
    else passes++;
    checks++;
    if ({done_b, dout_b, perr_b, ferr_b} !== 10'd0)
      $display("FAIL reset_b_outputs got %h exp 0", {done_b, dout_b, perr_b, ferr_b});
    else passes++;
    reset = 1'b0;
    wait_ticks(20);
    checks++;
    if (q_a.size() + q_b.size() !== 0)
      $display("FAIL reset_idle_done got %0d exp 0", q_a.size() + q_b.size());
    else passes++;
    checks++;
    if (dout_a !== 8'h00) $display("FAIL reset_idle_dout got %h exp 00", dout_a);
    else passes++;
  endtask

  task automatic test_parity_modes();
    q_a.delete();
    exp_a.delete();
    send_a(8'h55, 2'b00, 1'b0, 1'b1); exp_a.push_back(model(8'h55, 2'b00, 1'b0, 1'b1));
    send_a(8'hA3, 2'b01, 1'b0, 1'b1); exp_a.push_back(model(8'hA3, 2'b01, 1'b0, 1'b1));
    send_a(8'hA3, 2'b01, 1'b1, 1'b1); exp_a.push_back(model(8'hA3, 2'b01, 1'b1, 1'b1));
    send_a(8'h00, 2'b10, 1'b1, 1'b1); exp_a.push_back(model(8'h00, 2'b10, 1'b1, 1'b1));
    send_a(8'h00, 2'b10, 1'b0, 1'b1); exp_a.push_back(model(8'h00, 2'b10, 1'b0, 1'b1));
    send_a(8'h81, 2'b11, 1'b0, 1'b1); exp_a.push_back(model(8'h81, 2'b11, 1'b0, 1'b1));
    checks++;
    if (q_a.size() !== exp_a.size())
      $display("FAIL parity_modes_count got %0d exp %0d", q_a.size(), exp_a.size());
    else passes++;
    for (int i = 0; i < exp_a.size() && i < q_a.size(); i++) begin
      checks++;
      if (q_a[i] !== exp_a[i])
        $display("FAIL parity_modes_frame%0d got d=%h pe=%b fe=%b exp d=%h pe=%b fe=%b",
                 i, q_a[i].d, q_a[i].pe, q_a[i].fe, exp_a[i].d, exp_a[i].pe, exp_a[i].fe);
      else passes++;
    end
  endtask

  task automatic test_break();
    q_a.delete();
    pm_a = 2'b00;
    rx_a = 1'b0;
    wait_ticks(10 * OVS);
    rx_a = 1'b1;
    wait_ticks(32);
    checks++;
    if (q_a.size() !== 1) $display("FAIL break_count got %0d exp 1", q_a.size());
    else passes++;
    if (q_a.size() > 0) begin
      checks++;
      if (q_a[0] !== res_t'({8'h00, 1'b0, 1'b1}))
        $display("FAIL break_frame got d=%h pe=%b fe=%b exp d=00 pe=0 fe=1",
                 q_a[0].d, q_a[0].pe, q_a[0].fe);
      else passes++;
    end
    q_a.delete();
    send_a(8'h3C, 2'b00, 1'b0, 1'b1);
    checks++;
    if (q_a.size() !== 1 || q_a[0] !== model(8'h3C, 2'b00, 1'b0, 1'b1))
      $display("FAIL after_break got n=%0d d=%h fe=%b exp n=1 d=3c fe=0",
               q_a.size(), dout_a, ferr_a);
    else passes++;
  endtask

  task automatic test_glitch();
    q_a.delete();
    rx_a = 1'b0;
    wait_ticks(4);
    rx_a = 1'b1;
    wait_ticks(3 * OVS);
    checks++;
    if (q_a.size() !== 0) $display("FAIL glitch_no_done got %0d exp 0", q_a.size());
    else passes++;
    send_a(8'h0F, 2'b00, 1'b0, 1'b1);
    checks++;
    if (q_a.size() !== 1 || q_a[0] !== model(8'h0F, 2'b00, 1'b0, 1'b1))
      $display("FAIL after_glitch got n=%0d d=%h exp n=1 d=0f", q_a.size(), dout_a);
    else passes++;
  endtask

  task automatic test_reset_midframe();
    q_a.delete();
    pm_a = 2'b00;
    rx_a = 1'b0;
    wait_ticks(OVS);
    rx_a = 1'b1;
    wait_ticks(4 * OVS + OVS / 2);
    reset = 1'b1;
    #1;
    checks++;
    if ({done_a, dout_a, perr_a, ferr_a} !== 11'd0)
      $display("FAIL midframe_reset_outputs got %h exp 0", {done_a, dout_a, perr_a, ferr_a});
    else passes++;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    wait_ticks(6 * OVS);
    checks++;
    if (q_a.size() !== 0) $display("FAIL midframe_no_done got %0d exp 0", q_a.size());
    else passes++;
    send_a(8'hC3, 2'b00, 1'b0, 1'b1);
    checks++;
    if (q_a.size() !== 1 || q_a[0] !== model(8'hC3, 2'b00, 1'b0, 1'b1))
      $display("FAIL after_midframe_reset got n=%0d d=%h exp n=1 d=c3", q_a.size(), dout_a);
    else passes++;
  endtask

  task automatic test_dbit7();
    logic [6:0] d;
    logic [1:0] m;
    logic       p;
    q_b.delete();
    exp_b.delete();
    send_b(7'h5A, 2'b00, 1'b0);
    exp_b.push_back(model(8'h5A, 2'b00, 1'b0, 1'b1));
    for (int i = 0; i < 4; i++) begin
      d = 7'($urandom);
      m = 2'($urandom_range(0, 3));
      p = 1'($urandom_range(0, 1));
      send_b(d, m, p);
      exp_b.push_back(model({1'b0, d}, m, p, 1'b1));
    end
    checks++;
    if (q_b.size() !== exp_b.size())
      $display("FAIL dbit7_count got %0d exp %0d", q_b.size(), exp_b.size());
    else passes++;
    for (int i = 0; i < exp_b.size() && i < q_b.size(); i++) begin
      checks++;
      if (q_b[i] !== exp_b[i])
        $display("FAIL dbit7_frame%0d got d=%h pe=%b fe=%b exp d=%h pe=%b fe=%b",
                 i, q_b[i].d, q_b[i].pe, q_b[i].fe, exp_b[i].d, exp_b[i].pe, exp_b[i].fe);
      else passes++;
    end
  endtask

  // Frames follow each other with no idle gap unless the stop bit was driven low.
  task automatic test_back_to_back_random();
    logic [7:0] d;
    logic [1:0] m;
    logic       p, st;
    q_a.delete();
    exp_a.delete();
    for (int i = 0; i < 10; i++) begin
      d  = 8'($urandom);
      m  = 2'($urandom_range(0, 3));
      p  = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 3) != 0);
      send_a(d, m, p, st);
      exp_a.push_back(model(d, m, p, st));
      if (!st) wait_ticks(OVS);
    end
    checks++;
    if (q_a.size() !== exp_a.size())
      $display("FAIL random_count got %0d exp %0d", q_a.size(), exp_a.size());
    else passes++;
    for (int i = 0; i < exp_a.size() && i < q_a.size(); i++) begin
      checks++;
      if (q_a[i] !== exp_a[i])
        $display("FAIL random_frame%0d got d=%h pe=%b fe=%b exp d=%h pe=%b fe=%b",
                 i, q_a[i].d, q_a[i].pe, q_a[i].fe, exp_a[i].d, exp_a[i].pe, exp_a[i].fe);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_parity_modes();
    test_break();
    test_glitch();
    test_reset_midframe();
    test_dbit7();
    test_back_to_back_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
